// File: rtl/std_sync_arbiter.sv
// std_sync_arbiter: round-robin front end that shares one M-structure sync
// register between N writer ports and N reader ports. One register operation
// is in flight at a time (IDLE -> ISSUE -> RESP). Blocked operations produce
// no done pulse and simply compete again on a later IDLE.
//
// Optional build macro SYNC_ARB_SHADOW_EN: track the register's full/empty
// state locally so that only operations that can succeed are issued. Any
// blocked response then raises the sticky protocol_err flag.
module std_sync_arbiter #(
    parameter int WIDTH = 32,
    parameter int N     = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N-1:0]       write_req,
    input  logic [N*WIDTH-1:0] write_data,
    input  logic [N-1:0]       read_req,
    output logic [N-1:0]       write_done,
    output logic [N-1:0]       read_done,
    output logic [WIDTH-1:0]   read_data,
    output logic [WIDTH-1:0]   reg_in,
    output logic               reg_write_en,
    output logic               reg_read_en,
    input  logic [WIDTH-1:0]   reg_out,
    input  logic               reg_done,
    input  logic               reg_blocked,
    output logic               protocol_err
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t             state_q, state_d;
    logic               is_read_q, is_read_d;     // class of the current grant
    logic [IDX_W-1:0]   idx_q, idx_d;             // port index of the current grant
    logic [WIDTH-1:0]   data_q, data_d;           // latched write data
    logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               prefer_read_q, prefer_read_d;

    logic [N-1:0]       wr_elig;
    logic [N-1:0]       rd_elig;
    logic [IDX_W-1:0]   wr_pick;
    logic [IDX_W-1:0]   rd_pick;
    logic [IDX_W-1:0]   idx_next;
    logic               pick_read;

    // First requester at or after ptr, wrapping modulo N. The loop runs
    // downwards so the last hit written is the closest one to ptr.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0]     req,
                                                 input logic [IDX_W-1:0] ptr);
        int k;
        rr_pick = ptr;
        for (int i = N - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % N;
            if (req[IDX_W'(k)]) rr_pick = IDX_W'(k);
        end
    endfunction

    assign wr_pick  = rr_pick(wr_elig, wr_ptr_q);
    assign rd_pick  = rr_pick(rd_elig, rd_ptr_q);
    assign idx_next = IDX_W'((int'(idx_q) + 1) % N);

`ifdef SYNC_ARB_SHADOW_EN
    logic shadow_full_q, shadow_full_d;
    logic protocol_err_q, protocol_err_d;

    // Only the operation the register can accept is eligible.
    always_comb begin
        wr_elig = shadow_full_q ? '0 : write_req;
        rd_elig = shadow_full_q ? read_req : '0;
    end

    assign protocol_err = protocol_err_q;
`else
    // Every pending request is eligible; blocked ones are retried.
    always_comb begin
        wr_elig = write_req;
        rd_elig = read_req;
    end

    assign protocol_err = 1'b0;
`endif

    // Next-state, grant bookkeeping and register/port outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case
        // leaves one unassigned, which would infer a latch.
        state_d       = state_q;
        is_read_d     = is_read_q;
        idx_d         = idx_q;
        data_d        = data_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        prefer_read_d = prefer_read_q;
        pick_read     = 1'b0;
        write_done    = '0;
        read_done     = '0;
        read_data     = '0;
        reg_in        = '0;
        reg_write_en  = 1'b0;
        reg_read_en   = 1'b0;
`ifdef SYNC_ARB_SHADOW_EN
        shadow_full_d  = shadow_full_q;
        protocol_err_d = protocol_err_q;
`endif

        unique case (state_q)
            IDLE: begin
                if ((|wr_elig) || (|rd_elig)) begin
                    // Preferred class wins a tie; a lone class always wins.
                    pick_read = (|rd_elig) && (!(|wr_elig) || prefer_read_q);
                    is_read_d = pick_read;
                    idx_d     = pick_read ? rd_pick : wr_pick;
                    data_d    = pick_read ? '0 : write_data[wr_pick*WIDTH +: WIDTH];
                    state_d   = ISSUE;
                end
            end

            ISSUE: begin
                reg_write_en = !is_read_q;
                reg_read_en  = is_read_q;
                reg_in       = data_q;
                state_d      = RESP;
            end

            RESP: begin
                state_d       = IDLE;
                prefer_read_d = !prefer_read_q;
                if (is_read_q) begin
                    rd_ptr_d = idx_next;
                    if (!reg_blocked) begin
                        read_done[idx_q] = 1'b1;
                        read_data        = reg_out;
`ifdef SYNC_ARB_SHADOW_EN
                        shadow_full_d    = 1'b0;
`endif
                    end
                end else begin
                    wr_ptr_d = idx_next;
                    if (reg_done) begin
                        write_done[idx_q] = 1'b1;
`ifdef SYNC_ARB_SHADOW_EN
                        shadow_full_d     = 1'b1;
`endif
                    end
                end
`ifdef SYNC_ARB_SHADOW_EN
                // The shadow should have kept blocked operations from issuing.
                if (reg_blocked || (!is_read_q && !reg_done)) protocol_err_d = 1'b1;
`endif
            end

            default: state_d = IDLE;
        endcase
    end

    // State register; asynchronous reset returns to IDLE mid-operation.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge value of the others.
        if (!reset_n) begin
            state_q       <= IDLE;
            is_read_q     <= 1'b0;
            idx_q         <= '0;
            data_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            prefer_read_q <= 1'b0;
`ifdef SYNC_ARB_SHADOW_EN
            shadow_full_q  <= 1'b0;
            protocol_err_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            is_read_q     <= is_read_d;
            idx_q         <= idx_d;
            data_q        <= data_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            prefer_read_q <= prefer_read_d;
`ifdef SYNC_ARB_SHADOW_EN
            shadow_full_q  <= shadow_full_d;
            protocol_err_q <= protocol_err_d;
`endif
        end
    end

endmodule
